// File: rtl/io_pad_in_conditioner_pkg.sv
// Shared types and helpers for the input-pad conditioner.
// Optional feature macro used by this slice: IO_PAD_IBUF_EN (vendor IBUF in front of each synchroniser).
package io_cond_pkg;

    // Parameter limits supported by the conditioner
    localparam int MAX_CH   = 32;
    localparam int MAX_SYNC = 4;
    localparam int MAX_FILT = 255;

    // Per-channel filter state, derived from the confirmation counter
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_CONFIRM = 1'b1
    } filt_state_e;

    // Width of a counter able to hold values 0..filtCycles
    function automatic int cnt_width(input int filtCycles);
        return $clog2(filtCycles + 1);
    endfunction

endpackage

// File: rtl/io_pad_in_conditioner_chan.sv
// One pad channel: optional IBUF, synchroniser chain, glitch filter and edge-pulse registers.
// With IO_PAD_IBUF_EN defined the raw pad goes through a vendor IBUF; otherwise a plain wire.
module io_cond_chan
    import io_cond_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    input  logic en_i,
    output logic filt_o,
    output logic rise_d_o,
    output logic fall_d_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW       = cnt_width(FILT_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CYCLES - 1);

    logic                   padBuf;
    logic                   syncOut;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q, filt_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    filt_state_e            state;

`ifdef IO_PAD_IBUF_EN
    IBUF u_ibuf (
        .I (pad_i),
        .O (padBuf)
    );
`else
    assign padBuf = pad_i;
`endif

    assign syncOut = sync_q[SYNC_STAGES-1];

    // Filter next state: a new level must be seen FILT_CYCLES edges in a row before it is accepted
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        state  = (cnt_q == '0) ? ST_STABLE : ST_CONFIRM;
        case (state)
            ST_STABLE: begin
                if (syncOut != filt_q) begin
                    if (FILT_CYCLES == 1) begin
                        filt_d = syncOut;
                    end else begin
                        cnt_d = CNT_ONE;
                    end
                end
            end
            ST_CONFIRM: begin
                if (syncOut == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    filt_d = syncOut;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: cnt_d = '0;
        endcase
        rise_d = ~filt_q &  filt_d & en_i;
        fall_d =  filt_q & ~filt_d & en_i;
    end

    // Synchroniser chain, filter state and edge pulses all advance on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            filt_q <= RESET_VAL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], padBuf};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign filt_o   = filt_q;
    assign rise_d_o = rise_d;
    assign fall_d_o = fall_d;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/io_pad_in_conditioner.sv
// Multi-channel input-pad conditioner: per-channel sync/filter/edge detect, enable gating, change flag.
// Optional macro IO_PAD_IBUF_EN selects a vendor IBUF on every pad input inside each channel.
module io_pad_in_conditioner
    import io_cond_pkg::*;
#(
    parameter int   NUM_CH      = 3,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] iopad_fs_in,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] fs_in,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              any_change
);

    logic [NUM_CH-1:0] filtVec;
    logic [NUM_CH-1:0] riseNext;
    logic [NUM_CH-1:0] fallNext;
    logic              anyChange_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        io_cond_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RESET_VAL   (RESET_VAL)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .pad_i    (iopad_fs_in[i]),
            .en_i     (ch_en[i]),
            .filt_o   (filtVec[i]),
            .rise_d_o (riseNext[i]),
            .fall_d_o (fallNext[i]),
            .rise_o   (rise_pulse[i]),
            .fall_o   (fall_pulse[i])
        );
    end

    // Disabled channels read as low; the filter keeps running underneath
    assign fs_in = filtVec & ch_en;

    // Change flag registered on the same edge as the per-channel pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anyChange_q <= 1'b0;
        end else begin
            anyChange_q <= |(riseNext | fallNext);
        end
    end

    assign any_change = anyChange_q;

endmodule
